cnn: RTL and testbench

//  3x3 single-channel convolution engine with 8-bit output cutoff. On a start pulse it

---
 rtl/cnn.sv | 215 +++++++++++++++++++++
 tb/tb_cnn.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cnn.sv
// 3x3 single-channel convolution over a pre-padded 66x66 image, 64x64 8-bit results.
// Optional feature macro: CNN_CUTOFF_EN (clamp to 0..255 instead of wrap-around).
module cnn (
    input  logic        clk,
    input  logic        rst,
    input  logic        image_ready,
    output logic        image_rden_o,
    output logic [12:0] image_addr_o,
    input  logic [7:0]  image_i,
    input  logic        image_valid,
    output logic        filter_rden_o,
    output logic [3:0]  filter_addr_o,
    input  logic [7:0]  filter_i,
    input  logic        filter_valid,
    output logic        cnn_valid_o,
    output logic [7:0]  cnn_data_o
);
    localparam int unsigned IMG_W = 64;
    localparam int unsigned K     = 3;
    localparam int unsigned DW    = 8;
    localparam int unsigned PW    = IMG_W + 2;
    localparam int unsigned NPIX  = PW * PW;
    localparam int unsigned NOUT  = IMG_W * IMG_W;
    localparam int unsigned NW    = K * K;
    localparam int unsigned AW    = 13;
    localparam int unsigned FW    = 4;
    localparam int unsigned CW    = 7;
    localparam int unsigned PRODW = 17;
    localparam int unsigned SUMW  = 21;

    typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_FLUSH} state_t;

    state_t                  state_q, state_d;
    logic                    filter_rden_q, filter_rden_d;
    logic [FW-1:0]           filter_addr_q, filter_addr_d;
    logic                    image_rden_q, image_rden_d;
    logic [AW-1:0]           image_addr_q, image_addr_d;
    logic [FW-1:0]           w_cnt_q, w_cnt_d;
    logic signed [DW-1:0]    w_q [NW];
    logic signed [DW-1:0]    w_d [NW];
    logic [CW-1:0]           c_in_q, c_in_d, r_in_q, r_in_d;
    logic [DW-1:0]           lb0_q [PW];
    logic [DW-1:0]           lb0_d [PW];
    logic [DW-1:0]           lb1_q [PW];
    logic [DW-1:0]           lb1_d [PW];
    logic [DW-1:0]           win_q [NW];
    logic [DW-1:0]           win_d [NW];
    logic signed [PRODW-1:0] prod_q [NW];
    logic signed [PRODW-1:0] prod_d [NW];
    logic                    p1_valid_q, p1_valid_d;
    logic                    cnn_valid_q, cnn_valid_d;
    logic [DW-1:0]           cnn_data_q, cnn_data_d;
    logic [AW-1:0]           out_cnt_q, out_cnt_d;
    logic                    pix_en_c, start_c, w_last_c;
    logic signed [SUMW-1:0]  sum_c;
    logic [DW-1:0]           cut_c;

    assign start_c  = (state_q == S_IDLE) && image_ready;
    assign w_last_c = (state_q == S_LOAD_W) && filter_valid && (w_cnt_q == FW'(NW - 1));
    assign pix_en_c = image_valid && ((state_q == S_STREAM) || (state_q == S_FLUSH));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (image_ready) state_d = S_LOAD_W;
            S_LOAD_W: if (w_last_c) state_d = S_STREAM;
            S_STREAM: if (image_rden_q && (image_addr_q == AW'(NPIX - 1))) state_d = S_FLUSH;
            S_FLUSH:  if (cnn_valid_q && (out_cnt_q == AW'(NOUT - 1))) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Adder tree and output cutoff for stage 2
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < NW; k++) sum_c = sum_c + SUMW'(prod_q[k]);
`ifdef CNN_CUTOFF_EN
        if (sum_c < 0)                 cut_c = '0;
        else if (sum_c > 21'sd255)     cut_c = '1;
        else                           cut_c = sum_c[DW-1:0];
`else
        cut_c = sum_c[DW-1:0];
`endif
    end

    // Output, fetch and datapath next-values
    always_comb begin
        filter_rden_d = filter_rden_q;
        filter_addr_d = filter_addr_q;
        image_rden_d  = image_rden_q;
        image_addr_d  = image_addr_q;
        w_cnt_d       = w_cnt_q;
        w_d           = w_q;
        c_in_d        = c_in_q;
        r_in_d        = r_in_q;
        lb0_d         = lb0_q;
        lb1_d         = lb1_q;
        win_d         = win_q;
        prod_d        = prod_q;
        p1_valid_d    = 1'b0;
        cnn_valid_d   = p1_valid_q;
        cnn_data_d    = cnn_data_q;
        out_cnt_d     = out_cnt_q;

        if (filter_rden_q) begin
            if (filter_addr_q == FW'(NW - 1)) filter_rden_d = 1'b0;
            else                              filter_addr_d = filter_addr_q + FW'(1);
        end else if (start_c) begin
            filter_rden_d = 1'b1;
            filter_addr_d = '0;
        end

        if (start_c) begin
            w_cnt_d   = '0;
            c_in_d    = '0;
            r_in_d    = '0;
            out_cnt_d = '0;
        end

        if ((state_q == S_LOAD_W) && filter_valid) begin
            w_d[w_cnt_q] = filter_i;
            w_cnt_d      = w_cnt_q + FW'(1);
        end

        if (image_rden_q) begin
            if (image_addr_q == AW'(NPIX - 1)) image_rden_d = 1'b0;
            else                               image_addr_d = image_addr_q + AW'(1);
        end else if (w_last_c) begin
            image_rden_d = 1'b1;
            image_addr_d = '0;
        end

        // Column of three vertically adjacent pixels enters the window on the right
        if (pix_en_c) begin
            lb0_d[c_in_q] = lb1_q[c_in_q];
            lb1_d[c_in_q] = image_i;
            for (int i = 0; i < K; i++) begin
                win_d[3*i]     = win_q[3*i+1];
                win_d[3*i+1]   = win_q[3*i+2];
            end
            win_d[2] = lb0_q[c_in_q];
            win_d[5] = lb1_q[c_in_q];
            win_d[8] = image_i;
            for (int k = 0; k < NW; k++)
                prod_d[k] = $signed({9'b0, win_d[k]}) * $signed({{9{w_q[k][DW-1]}}, w_q[k]});
            p1_valid_d = (r_in_q >= CW'(2)) && (c_in_q >= CW'(2));
            if (c_in_q == CW'(PW - 1)) begin
                c_in_d = '0;
                r_in_d = (r_in_q == CW'(PW - 1)) ? '0 : r_in_q + CW'(1);
            end else begin
                c_in_d = c_in_q + CW'(1);
            end
        end

        if (p1_valid_q) cnn_data_d = cut_c;
        if (cnn_valid_q) out_cnt_d = out_cnt_q + AW'(1);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            filter_rden_q <= 1'b0;
            filter_addr_q <= '0;
            image_rden_q  <= 1'b0;
            image_addr_q  <= '0;
            w_cnt_q       <= '0;
            c_in_q        <= '0;
            r_in_q        <= '0;
            p1_valid_q    <= 1'b0;
            cnn_valid_q   <= 1'b0;
            cnn_data_q    <= '0;
            out_cnt_q     <= '0;
            for (int k = 0; k < NW; k++) begin
                w_q[k]    <= '0;
                win_q[k]  <= '0;
                prod_q[k] <= '0;
            end
            for (int k = 0; k < PW; k++) begin
                lb0_q[k] <= '0;
                lb1_q[k] <= '0;
            end
        end else begin
            filter_rden_q <= filter_rden_d;
            filter_addr_q <= filter_addr_d;
            image_rden_q  <= image_rden_d;
            image_addr_q  <= image_addr_d;
            w_cnt_q       <= w_cnt_d;
            c_in_q        <= c_in_d;
            r_in_q        <= r_in_d;
            p1_valid_q    <= p1_valid_d;
            cnn_valid_q   <= cnn_valid_d;
            cnn_data_q    <= cnn_data_d;
            out_cnt_q     <= out_cnt_d;
            w_q           <= w_d;
            win_q         <= win_d;
            prod_q        <= prod_d;
            lb0_q         <= lb0_d;
            lb1_q         <= lb1_d;
        end
    end

    assign filter_rden_o = filter_rden_q;
    assign filter_addr_o = filter_addr_q;
    assign image_rden_o  = image_rden_q;
    assign image_addr_o  = image_addr_q;
    assign cnn_valid_o   = cnn_valid_q;
    assign cnn_data_o    = cnn_data_q;
endmodule

// File: tb/tb_cnn.sv
// Bench for cnn: memory responders, output monitor and a direct-formula convolution model.
// Follows CNN_CUTOFF_EN in the same way as the design.
module tb_cnn;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        image_ready = 1'b0;
    logic        image_rden_o;
    logic [12:0] image_addr_o;
    logic [7:0]  image_i = '0;
    logic        image_valid = 1'b0;
    logic        filter_rden_o;
    logic [3:0]  filter_addr_o;
    logic [7:0]  filter_i = '0;
    logic        filter_valid = 1'b0;
    logic        cnn_valid_o;
    logic [7:0]  cnn_data_o;

    logic [7:0]  img_mem [0:4355];
    logic [7:0]  w_mem   [0:8];
    logic [7:0]  results [$];
    int          f_reads = 0, i_reads = 0, addr_bad = 0;
    int          checks = 0, errors = 0;
    int          lat;

    cnn dut (
        .clk(clk), .rst(rst), .image_ready(image_ready),
        .image_rden_o(image_rden_o), .image_addr_o(image_addr_o),
        .image_i(image_i), .image_valid(image_valid),
        .filter_rden_o(filter_rden_o), .filter_addr_o(filter_addr_o),
        .filter_i(filter_i), .filter_valid(filter_valid),
        .cnn_valid_o(cnn_valid_o), .cnn_data_o(cnn_data_o)
    );

    always #5 clk = ~clk;

    // Memories answer one cycle after a read enable
    always @(posedge clk) begin
        image_valid  <= image_rden_o;
        image_i      <= (image_addr_o < 13'd4356) ? img_mem[image_addr_o] : 8'h00;
        filter_valid <= filter_rden_o;
        filter_i     <= (filter_addr_o < 4'd9) ? w_mem[filter_addr_o] : 8'h00;
    end

    // Monitor away from the active edge
    always @(negedge clk) begin
        if (cnn_valid_o) results.push_back(cnn_data_o);
        if (filter_rden_o) begin
            if (filter_addr_o !== 4'(f_reads)) addr_bad++;
            f_reads++;
        end
        if (image_rden_o) begin
            if (image_addr_o !== 13'(i_reads)) addr_bad++;
            i_reads++;
        end
    end

    function automatic logic [7:0] ref_y(input int r, input int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'($signed(w_mem[3*i+j])) * int'(img_mem[(r+i)*66 + c + j]);
`ifdef CNN_CUTOFF_EN
        if (s < 0)   return 8'h00;
        if (s > 255) return 8'hFF;
`endif
        return 8'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // kinds: image 0=const 1=addr&0xFF 2=random; weights 0=const 1=identity 2=random
    task automatic load(input int ik, input logic [7:0] iv, input int wk, input logic [7:0] wv);
        for (int a = 0; a < 4356; a++)
            img_mem[a] = (ik == 0) ? iv : (ik == 1) ? 8'(a) : 8'($urandom);
        for (int k = 0; k < 9; k++)
            w_mem[k] = (wk == 0) ? wv : (wk == 1) ? ((k == 4) ? 8'h01 : 8'h00) : 8'($urandom);
    endtask

    task automatic run(input int pulse2_at, input int rst_at, output int latency);
        int cyc;
        @(posedge clk);
        results.delete();
        f_reads = 0; i_reads = 0; addr_bad = 0;
        @(negedge clk); image_ready = 1'b1;
        @(negedge clk); image_ready = 1'b0;
        cyc = 1;
        latency = -1;
        while (cyc < 6000) begin
            #1;
            if (results.size() == 4096) begin
                latency = cyc;
                break;
            end
            if (rst_at > 0 && results.size() >= rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            image_ready = (cyc == pulse2_at);
            @(negedge clk);
            cyc++;
        end
        image_ready = 1'b0;
    endtask

    task automatic verify(input string tag, input int latency);
        int bad = 0, first = -1;
        chk({tag, "_count"}, results.size(), 4096);
        chk({tag, "_filter_reads"}, f_reads, 9);
        chk({tag, "_image_reads"}, i_reads, 4356);
        chk({tag, "_addr_order_errs"}, addr_bad, 0);
        chk({tag, "_latency_ok"}, 32'(latency > 0 && latency <= 4400), 1);
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                if (r*64 + c < results.size() && results[r*64 + c] !== ref_y(r, c)) begin
                    if (first < 0) first = r*64 + c;
                    bad++;
                end
        if (first >= 0)
            $display("first bad result index %0d: got 0x%0h want 0x%0h",
                     first, results[first], ref_y(first / 64, first % 64));
        chk({tag, "_model_mismatches"}, bad, 0);
    endtask

    initial begin
        logic [7:0] r0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {13'b0, filter_rden_o, filter_addr_o, image_rden_o,
                              image_addr_o, cnn_valid_o, cnn_data_o}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_rden_before_start", f_reads + i_reads, 0);

        load(0, 8'h01, 0, 8'h01);
        run(0, 0, lat);
        verify("ones", lat);
        r0 = results[4095];
        chk("ones_last", r0, 8'h09);

        load(1, 8'h00, 1, 8'h00);
        run(0, 0, lat);
        verify("identity", lat);
        r0 = results[0];
        chk("identity_y00", r0, 8'h43);

        load(0, 8'hFF, 0, 8'h7F);
        run(0, 0, lat);
        r0 = results[0];
`ifdef CNN_CUTOFF_EN
        chk("sat_pos", r0, 8'hFF);
`else
        chk("wrap_pos", r0, 8'h89);
`endif
        verify("w7f", lat);

        load(0, 8'hFF, 0, 8'h80);
        run(0, 0, lat);
        r0 = results[0];
`ifdef CNN_CUTOFF_EN
        chk("relu_neg", r0, 8'h00);
`else
        chk("wrap_neg", r0, 8'h80);
`endif
        verify("w80", lat);

        load(2, 8'h00, 2, 8'h00);
        run(2000, 0, lat);
        verify("rand_pulse_in_stream", lat);
        repeat (30) @(negedge clk);
        chk("no_extra_results", results.size(), 4096);
        chk("no_extra_image_reads", i_reads, 4356);

        load(2, 8'h00, 2, 8'h00);
        run(0, 0, lat);
        verify("rand_rerun", lat);

        load(2, 8'h00, 2, 8'h00);
        run(0, 1000, lat);
        chk("rst_outputs_low", {29'b0, cnn_valid_o, image_rden_o, filter_rden_o}, 0);
        repeat (30) @(negedge clk);
        chk("rst_results_stop", results.size(), 1000);
        run(0, 0, lat);
        verify("after_reset", lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
